// File: rtl/pmod_da2_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pmod_da2_serializer_if                                          |
// | Purpose  : Bundles the sample handshake and PmodDA2 pin signals of the     |
// |            dual-DAC serializer so source, serializer and bench share one   |
// |            connection.                                                     |
// | Signals  : start        sample strobe from the sample-rate source          |
// |            data1/data2  12-bit unsigned samples for DAC 1 / DAC 2          |
// |            clr_overrun  clears the sticky overrun flag                     |
// |            D1/D2        serial data to DAC 1 / DAC 2                       |
// |            SCLK         serial clock                                       |
// |            nSYNC        frame select, active low                           |
// |            busy/done    frame-in-progress level / return-to-idle pulse     |
// |            overrun      sticky dropped-sample flag                         |
// | Modports : master drives the sample side, slave is the serializer.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface pmod_da2_serializer_if;
   logic        start;
   logic [11:0] data1;
   logic [11:0] data2;
   logic        clr_overrun;
   logic        D1;
   logic        D2;
   logic        SCLK;
   logic        nSYNC;
   logic        busy;
   logic        done;
   logic        overrun;

   modport master (
      output start, data1, data2, clr_overrun,
      input  D1, D2, SCLK, nSYNC, busy, done, overrun
   );

   modport slave (
      input  start, data1, data2, clr_overrun,
      output D1, D2, SCLK, nSYNC, busy, done, overrun
   );
endinterface
`default_nettype wire

// File: rtl/pmod_da2_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pmod_da2_serializer                                             |
// | Purpose  : Takes two 12-bit samples on a start strobe and shifts them out  |
// |            to both DAC121S101 chips of a PmodDA2 as one 16-bit frame,      |
// |            generating SCLK, nSYNC and D1/D2 from the system clock. Reports |
// |            busy/done and flags samples dropped while a frame is in flight. |
// | Params   : CLK_DIV    clock cycles per SCLK half-period (>=1)              |
// |            QUIET_CYC  nSYNC-high cycles after a frame (>=1)                |
// | Ports    : clock  system clock                                             |
// |            RST_N  asynchronous active-low reset                            |
// |            bus    pmod_da2_serializer_if.slave (handshake + DAC pins)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pmod_da2_serializer #(
   parameter int CLK_DIV   = 2,
   parameter int QUIET_CYC = 4
) (
   input  logic                  clock,
   input  logic                  RST_N,
   pmod_da2_serializer_if.slave  bus
);

   localparam int PH_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
   localparam int Q_W  = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

   // Last phase count of a bit, and the first phase count of its low half.
   localparam logic [PH_W-1:0] C_PH_LAST = PH_W'(2 * CLK_DIV - 1);
   localparam logic [PH_W-1:0] C_PH_LOW  = PH_W'(CLK_DIV);
   localparam logic [Q_W-1:0]  C_Q_LAST  = Q_W'(QUIET_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      QUIET = 2'd2
   } state_t;

   // ---------------------------------------------------------------- state
   state_t            r_state;
   logic [PH_W-1:0]   r_ph;
   logic [3:0]        r_bit;
   logic [Q_W-1:0]    r_q;
   logic [15:0]       r_sr1;
   logic [15:0]       r_sr2;
   logic              r_start_d;

   // Registered pins.
   logic              r_d1;
   logic              r_d2;
   logic              r_sclk;
   logic              r_nsync;
   logic              r_busy;
   logic              r_done;
   logic              r_overrun;

   // ---------------------------------------------------------- next values
   state_t            w_state_n;
   logic [PH_W-1:0]   w_ph_n;
   logic [3:0]        w_bit_n;
   logic [Q_W-1:0]    w_q_n;
   logic [15:0]       w_sr1_n;
   logic [15:0]       w_sr2_n;
   logic              w_in_shift;
   logic              w_d1_n;
   logic              w_d2_n;
   logic              w_sclk_n;
   logic              w_nsync_n;
   logic              w_busy_n;
   logic              w_done_n;
   logic              w_overrun_n;
   logic              w_ovr_set;

   always_ff @(posedge clock or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= IDLE;
         r_ph      <= '0;
         r_bit     <= 4'd0;
         r_q       <= '0;
         r_sr1     <= 16'h0000;
         r_sr2     <= 16'h0000;
         r_start_d <= 1'b0;
         r_d1      <= 1'b0;
         r_d2      <= 1'b0;
         r_sclk    <= 1'b1;
         r_nsync   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_ph      <= w_ph_n;
         r_bit     <= w_bit_n;
         r_q       <= w_q_n;
         r_sr1     <= w_sr1_n;
         r_sr2     <= w_sr2_n;
         r_start_d <= bus.start;
         r_d1      <= w_d1_n;
         r_d2      <= w_d2_n;
         r_sclk    <= w_sclk_n;
         r_nsync   <= w_nsync_n;
         r_busy    <= w_busy_n;
         r_done    <= w_done_n;
         r_overrun <= w_overrun_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_ph_n    = r_ph;
      w_bit_n   = r_bit;
      w_q_n     = r_q;
      w_sr1_n   = r_sr1;
      w_sr2_n   = r_sr2;
      w_done_n  = 1'b0;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               // Top two bits are don't-care, PD bits 00 select normal operation.
               w_sr1_n   = {4'b0000, bus.data1};
               w_sr2_n   = {4'b0000, bus.data2};
               w_bit_n   = 4'd15;
               w_ph_n    = '0;
               w_state_n = SHIFT;
            end
         end

         SHIFT: begin
            if (r_ph == C_PH_LAST) begin
               // End of the low half: the DAC has taken this bit, present the next.
               w_ph_n  = '0;
               w_sr1_n = {r_sr1[14:0], 1'b0};
               w_sr2_n = {r_sr2[14:0], 1'b0};
               w_bit_n = r_bit - 4'd1;
               if (r_bit == 4'd0) begin
                  w_state_n = QUIET;
                  w_q_n     = C_Q_LAST;
               end
            end else begin
               w_ph_n = r_ph + 1'b1;
            end
         end

         QUIET: begin
            if (r_q == '0) begin
               w_state_n = IDLE;
               w_done_n  = 1'b1;
            end else begin
               w_q_n = r_q - 1'b1;
            end
         end

         default: begin
            w_state_n = IDLE;
         end
      endcase

      // Pins are derived from the next state so they change on the same edge
      // as the state they describe.
      w_in_shift = (w_state_n == SHIFT);
      w_nsync_n  = ~w_in_shift;
      w_sclk_n   = ~w_in_shift | (w_ph_n < C_PH_LOW);
      w_d1_n     = w_in_shift & w_sr1_n[15];
      w_d2_n     = w_in_shift & w_sr2_n[15];
      w_busy_n   = (w_state_n != IDLE);

      // A start level held high continuously since its accepting edge is the
      // same strobe re-presented (back-to-back mode), not a dropped sample;
      // only a fresh assertion during a frame counts as an overrun.
      w_ovr_set = bus.start & ~r_start_d & (r_state != IDLE);
      if (w_ovr_set) begin
         w_overrun_n = 1'b1;
      end else if (bus.clr_overrun) begin
         w_overrun_n = 1'b0;
      end else begin
         w_overrun_n = r_overrun;
      end
   end

   assign bus.D1      = r_d1;
   assign bus.D2      = r_d2;
   assign bus.SCLK    = r_sclk;
   assign bus.nSYNC   = r_nsync;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.overrun = r_overrun;

endmodule
`default_nettype wire
